// File: rtl/win_kernel_sched_if.sv
// Kernel-memory, transform-engine and U-buffer bus of the
// Winograd kernel sequencer.
interface win_kernel_sched_if #(
  parameter int KADDR_W = 9,
  parameter int UADDR_W = 10
);
  logic               kmem_rd;
  logic [KADDR_W-1:0] kmem_addr;
  logic [47:0]        kmem_rdata;
  logic               xf_enable;
  logic [47:0]        xf_kernel1;
  logic [47:0]        xf_kernel2;
  logic [47:0]        xf_kernel3;
  logic               xf_end;
  logic [63:0]        xf_u1;
  logic [63:0]        xf_u2;
  logic [63:0]        xf_u3;
  logic [63:0]        xf_u4;
  logic               umem_we;
  logic [UADDR_W-1:0] umem_addr;
  logic [63:0]        umem_wdata;
  logic               umem_ready;

  modport master (
    output kmem_rd, kmem_addr,
    input  kmem_rdata,
    output xf_enable, xf_kernel1, xf_kernel2, xf_kernel3,
    input  xf_end, xf_u1, xf_u2, xf_u3, xf_u4,
    output umem_we, umem_addr, umem_wdata,
    input  umem_ready
  );

  modport slave (
    input  kmem_rd, kmem_addr,
    output kmem_rdata,
    input  xf_enable, xf_kernel1, xf_kernel2, xf_kernel3,
    output xf_end, xf_u1, xf_u2, xf_u3, xf_u4,
    input  umem_we, umem_addr, umem_wdata,
    output umem_ready
  );
endinterface

// File: rtl/win_kernel_sched.sv
// Sequencer that walks 3x3 kernels through the Winograd F(2,3)
// kernel-transform engine and stores each 4x4 U tile as four rows.
module win_kernel_sched #(
  parameter int KADDR_W  = 9,
  parameter int UADDR_W  = 10,
  parameter int KCNT_W   = 8,
  parameter int WD_LIMIT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [KCNT_W-1:0]  cfg_count,
  input  logic [KADDR_W-1:0] cfg_kbase,
  input  logic [UADDR_W-1:0] cfg_ubase,
  output logic               busy,
  output logic               done,
  output logic               err,
  win_kernel_sched_if.master bus
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_FETCH = 4'd1;
  localparam logic [3:0] S_LAST  = 4'd2;
  localparam logic [3:0] S_GO    = 4'd3;
  localparam logic [3:0] S_WAIT  = 4'd4;
  localparam logic [3:0] S_CAP   = 4'd5;
  localparam logic [3:0] S_WRITE = 4'd6;
  localparam logic [3:0] S_NEXT  = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  localparam int WD_W = $clog2(WD_LIMIT + 1);

  logic [3:0]         state_q, state_d;
  logic [1:0]         sub_q, sub_d;
  logic [KCNT_W-1:0]  k_q, k_d;
  logic [KCNT_W-1:0]  cnt_q, cnt_d;
  logic [KADDR_W-1:0] kptr_q, kptr_d;
  logic [UADDR_W-1:0] uptr_q, uptr_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               err_q, err_d;
  logic [47:0]        kr1_q, kr1_d;
  logic [47:0]        kr2_q, kr2_d;
  logic [47:0]        kr3_q, kr3_d;
  logic [3:0][63:0]   u_q, u_d;

  // Address pointers advance per read / accepted write and wrap naturally.
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    kptr_d  = kptr_q;
    uptr_d  = uptr_q;
    wd_d    = wd_q;
    err_d   = err_q;
    kr1_d   = kr1_q;
    kr2_d   = kr2_q;
    kr3_d   = kr3_q;
    u_d     = u_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = cfg_count;
          kptr_d  = cfg_kbase;
          uptr_d  = cfg_ubase;
          err_d   = 1'b0;
          k_d     = '0;
          sub_d   = '0;
          state_d = (cfg_count == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        kptr_d = kptr_q + 1'b1;
        sub_d  = sub_q + 1'b1;
        if (sub_q == 2'd1) kr3_d = bus.kmem_rdata;
        if (sub_q == 2'd2) begin
          kr2_d   = bus.kmem_rdata;
          sub_d   = '0;
          state_d = S_LAST;
        end
      end
      S_LAST: begin
        kr1_d   = bus.kmem_rdata;
        state_d = S_GO;
      end
      S_GO: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + 1'b1;
        if (bus.xf_end) begin
          state_d = S_CAP;
        end else if (wd_q + 1'b1 == WD_W'(WD_LIMIT)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_CAP: begin
        u_d     = {bus.xf_u4, bus.xf_u3, bus.xf_u2, bus.xf_u1};
        sub_d   = '0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (bus.umem_ready) begin
          uptr_d = uptr_q + 1'b1;
          sub_d  = sub_q + 1'b1;
          if (sub_q == 2'd3) state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        k_d     = k_q + 1'b1;
        sub_d   = '0;
        state_d = (k_q + 1'b1 == cnt_q) ? S_DONE : S_FETCH;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sub_q   <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      kptr_q  <= '0;
      uptr_q  <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      kr1_q   <= '0;
      kr2_q   <= '0;
      kr3_q   <= '0;
      u_q     <= '0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      kptr_q  <= kptr_d;
      uptr_q  <= uptr_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      kr1_q   <= kr1_d;
      kr2_q   <= kr2_d;
      kr3_q   <= kr3_d;
      u_q     <= u_d;
    end
  end

  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done = (state_q == S_DONE);
  assign err  = err_q;

  assign bus.kmem_rd    = (state_q == S_FETCH);
  assign bus.kmem_addr  = bus.kmem_rd ? kptr_q : '0;
  assign bus.xf_enable  = (state_q == S_GO);
  assign bus.xf_kernel1 = kr1_q;
  assign bus.xf_kernel2 = kr2_q;
  assign bus.xf_kernel3 = kr3_q;
  assign bus.umem_we    = (state_q == S_WRITE);
  assign bus.umem_addr  = bus.umem_we ? uptr_q : '0;
  assign bus.umem_wdata = bus.umem_we ? u_q[sub_q] : '0;

endmodule

// File: tb/tb_win_kernel_sched.sv
// Randomised bench for win_kernel_sched: memory, engine model
// and a scoreboard built from the kernel list in memory.
module tb_win_kernel_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] cfg_count = '0;
  logic [8:0] cfg_kbase = '0;
  logic [9:0] cfg_ubase = '0;
  logic       busy, done, err;

  win_kernel_sched_if #(.KADDR_W(9), .UADDR_W(10)) bus ();

  win_kernel_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_count (cfg_count),
    .cfg_kbase (cfg_kbase),
    .cfg_ubase (cfg_ubase),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Integer G*g*G^T; element j of a U row sits at bits [63-16j -: 16].
  function automatic int el(input logic [47:0] w, input int j);
    logic [15:0] s;
    s = w[16*j +: 16];
    return int'($signed(s));
  endfunction

  function automatic logic [255:0] xform(input logic [47:0] top,
                                         input logic [47:0] mid,
                                         input logic [47:0] bot);
    int a [4][3];
    int u [4][4];
    logic [255:0] r;
    for (int j = 0; j < 3; j++) begin
      a[0][j] = el(top, j);
      a[1][j] = (el(top, j) + el(mid, j) + el(bot, j)) >>> 1;
      a[2][j] = (el(top, j) - el(mid, j) + el(bot, j)) >>> 1;
      a[3][j] = el(bot, j);
    end
    for (int i = 0; i < 4; i++) begin
      u[i][0] = a[i][0];
      u[i][1] = (a[i][0] + a[i][1] + a[i][2]) >>> 1;
      u[i][2] = (a[i][0] - a[i][1] + a[i][2]) >>> 1;
      u[i][3] = a[i][2];
      r[64*i +: 64] = {16'(u[i][0]), 16'(u[i][1]),
                       16'(u[i][2]), 16'(u[i][3])};
    end
    return r;
  endfunction

  logic [47:0] mem [512];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    bus.kmem_rdata <= bus.kmem_rd ? mem[bus.kmem_addr]
                                  : {$urandom, $urandom};

  // Engine: end pulse two cycles after enable, U valid one cycle after that.
  bit           eng_dead = 1'b0;
  logic         stray = 1'b0;
  int           ph;
  logic         e_end;
  logic [255:0] res;
  logic [63:0]  eu [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph    <= 0;
      e_end <= 1'b0;
      res   <= '0;
      for (int i = 0; i < 4; i++) eu[i] <= '0;
    end else begin
      e_end <= 1'b0;
      for (int i = 0; i < 4; i++) eu[i] <= {$urandom, $urandom};
      if (ph == 0) begin
        if (bus.xf_enable && !eng_dead) begin
          res <= xform(bus.xf_kernel3, bus.xf_kernel2, bus.xf_kernel1);
          ph  <= 1;
        end
      end else if (ph == 1) begin
        e_end <= 1'b1;
        ph    <= 2;
      end else begin
        for (int i = 0; i < 4; i++) eu[i] <= res[64*i +: 64];
        ph <= 0;
      end
    end
  end

  assign bus.xf_end = e_end | stray;
  assign bus.xf_u1  = eu[0];
  assign bus.xf_u2  = eu[1];
  assign bus.xf_u3  = eu[2];
  assign bus.xf_u4  = eu[3];

  logic [8:0]  exp_rd [$];
  logic [9:0]  exp_wa [$];
  logic [63:0] exp_wd [$];
  logic [63:0] wr_log [$];
  logic [8:0]  cur_kb;
  int rd_cnt, wr_cnt, en_cnt, done_cnt, stall_cyc, exp_en;
  int te, tdone;
  int rmode = 0;
  int sbeat, sleft;

  always @(negedge clk) begin
    logic rdy;
    logic [8:0] a;
    if (rst_n) begin
      rdy = 1'b1;
      if (rmode == 1) rdy = ($urandom_range(3) != 0);
      if (rmode == 2 && bus.umem_we && wr_cnt == sbeat && sleft > 0) begin
        rdy = 1'b0;
        sleft--;
      end
      bus.umem_ready = rdy;
      if (bus.kmem_rd) begin
        if (rd_cnt < exp_rd.size())
          chk("rd_addr", bus.kmem_addr, exp_rd[rd_cnt]);
        else
          chk("rd_extra", rd_cnt, exp_rd.size());
        rd_cnt++;
      end
      if (bus.umem_we) begin
        if (wr_cnt < exp_wa.size()) begin
          chk("wr_addr", bus.umem_addr, exp_wa[wr_cnt]);
          chk("wr_data", bus.umem_wdata, exp_wd[wr_cnt]);
        end else begin
          chk("wr_extra", wr_cnt, exp_wa.size());
        end
        if (rdy) begin
          wr_log.push_back(bus.umem_wdata);
          wr_cnt++;
        end else begin
          stall_cyc++;
        end
      end
      if (bus.xf_enable) begin
        te = cyc;
        if (en_cnt < exp_en) begin
          a = 9'(int'(cur_kb) + 3 * en_cnt);
          chk("xf_kernel3", bus.xf_kernel3, mem[a]);
          chk("xf_kernel2", bus.xf_kernel2, mem[9'(a + 9'd1)]);
          chk("xf_kernel1", bus.xf_kernel1, mem[9'(a + 9'd2)]);
        end else begin
          chk("en_extra", en_cnt, exp_en);
        end
        en_cnt++;
      end
      if (done) begin
        done_cnt++;
        tdone = cyc;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic setup(input int n, input logic [8:0] kb,
                       input logic [9:0] ub, input bit dead);
    logic [255:0] x;
    logic [8:0] a;
    exp_rd.delete();
    exp_wa.delete();
    exp_wd.delete();
    wr_log.delete();
    rd_cnt = 0; wr_cnt = 0; en_cnt = 0; done_cnt = 0; stall_cyc = 0;
    cur_kb = kb;
    eng_dead = dead;
    exp_en = dead ? (n > 0 ? 1 : 0) : n;
    for (int k = 0; k < n; k++) begin
      if (!(dead && k > 0)) begin
        a = 9'(int'(kb) + 3 * k);
        for (int i = 0; i < 3; i++) exp_rd.push_back(9'(a + 9'(i)));
      end
      if (!dead) begin
        x = xform(mem[a], mem[9'(a + 9'd1)], mem[9'(a + 9'd2)]);
        for (int r = 0; r < 4; r++) begin
          exp_wa.push_back(10'(int'(ub) + 4 * k + r));
          exp_wd.push_back(x[64*r +: 64]);
        end
      end
    end
  endtask

  task automatic do_run(input string tag, input int n, input logic [8:0] kb,
                        input logic [9:0] ub, input bit dead, input bit poke);
    int t0;
    int guard;
    setup(n, kb, ub, dead);
    cfg_count = 8'(n);
    cfg_kbase = kb;
    cfg_ubase = ub;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    cfg_count = 8'($urandom);
    cfg_kbase = 9'($urandom);
    cfg_ubase = 10'($urandom);
    chk({tag, "_err_clr"}, err, 1'b0);
    chk({tag, "_busy"}, busy, (n > 0));
    guard = 0;
    while (done_cnt == 0 && guard < 2000) begin
      start = poke && (guard % 4 == 1);
      tick();
      guard++;
    end
    start = poke;
    if (done_cnt == 0) begin
      chk({tag, "_timeout"}, done_cnt, 1);
    end else if (dead) begin
      chk({tag, "_wd_lat"}, tdone - te, 9);
    end else begin
      chk({tag, "_lat"}, tdone - t0, 13 * n + 1 + stall_cyc);
    end
    tick();
    start = 1'b0;
    chk({tag, "_err"}, err, dead);
    chk({tag, "_rd_n"}, rd_cnt, exp_rd.size());
    chk({tag, "_wr_n"}, wr_cnt, exp_wa.size());
    chk({tag, "_en_n"}, en_cnt, exp_en);
    repeat (3) tick();
    chk({tag, "_one_done"}, done_cnt, 1);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {busy, done, err, bus.kmem_rd, bus.xf_enable,
                        bus.umem_we}, '0);
    chk({tag, "_kaddr"}, bus.kmem_addr, '0);
    chk({tag, "_uaddr"}, bus.umem_addr, '0);
    chk({tag, "_wdata"}, bus.umem_wdata, '0);
    chk({tag, "_k1"}, bus.xf_kernel1, '0);
    chk({tag, "_k2"}, bus.xf_kernel2, '0);
    chk({tag, "_k3"}, bus.xf_kernel3, '0);
  endtask

  initial begin
    int guard;
    bus.umem_ready = 1'b1;
    for (int i = 0; i < 512; i++) mem[i] = {$urandom, $urandom};
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    mem[0] = 48'h0;
    mem[1] = 48'h0000_0004_0000;
    mem[2] = 48'h0;
    do_run("centre", 1, 9'd0, 10'd0, 1'b0, 1'b0);
    chk("centre_n", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      chk("centre_u1", wr_log[0], 64'h0);
      chk("centre_u2", wr_log[1], 64'h0000_0001_FFFF_0000);
      chk("centre_u3", wr_log[2], 64'h0000_FFFF_0001_0000);
      chk("centre_u4", wr_log[3], 64'h0);
    end

    do_run("wrap", 3, 9'd9, 10'h3FC, 1'b0, 1'b0);

    rmode = 2; sbeat = 2; sleft = 5;
    do_run("stall", 2, 9'($urandom), 10'($urandom), 1'b0, 1'b0);
    chk("stall_cyc", stall_cyc, 5);
    rmode = 0;

    do_run("wdog", 2, 9'($urandom), 10'($urandom), 1'b1, 1'b0);
    do_run("wdog_next", 1, 9'($urandom), 10'($urandom), 1'b0, 1'b0);

    stray = 1'b1;
    tick();
    stray = 1'b0;
    tick();
    chk("stray_idle", busy, 1'b0);
    do_run("zero", 0, 9'($urandom), 10'($urandom), 1'b0, 1'b1);
    do_run("poke", 2, 9'($urandom), 10'($urandom), 1'b0, 1'b1);
    do_run("kwrap", 2, 9'd508, 10'($urandom), 1'b0, 1'b0);

    rmode = 1;
    for (int it = 0; it < 6; it++)
      do_run("rand", $urandom_range(1, 5), 9'($urandom), 10'($urandom),
             1'b0, 1'b0);
    rmode = 0;

    setup(3, 9'd100, 10'd200, 1'b0);
    cfg_count = 8'd3; cfg_kbase = 9'd100; cfg_ubase = 10'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!bus.umem_we && guard < 200) begin
      tick();
      guard++;
    end
    chk("mid_we_seen", bus.umem_we, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("mid_no_done", done_cnt, 0);
    chk("mid_idle", busy, 1'b0);
    do_run("post_rst", 1, 9'($urandom), 10'($urandom), 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
